// File: rtl/if_pc_ctrl.sv
// Instruction-fetch PC controller: owns the PC, requests instruction words and registers them into the IF/ID outputs.
// Latency: a word accepted on one rising edge appears on if_* on the next; one bubble cycle after reset and after every redirect.
// Backpressure: stall with a live if_valid holds if_*, pc and fetch_count and drops imem_req; imem_addr stays put while memory is waiting.
module if_pc_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h00000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_valid,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  output logic [31:0] if_npc,
  output logic [31:0] fetch_count
);

  localparam logic [1:0] S_BOOT  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;

  logic [1:0]  state;
  logic [1:0]  state_nxt;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        hold;
  logic        accept;

  // Address arithmetic wraps naturally at 2^32.
  assign pc_plus4 = pc + 32'd4;

  // A live instruction that the hazard unit is holding blocks new fetches.
  assign hold = stall & if_valid;

  // Request only in FETCH and never while reset is applied.
  assign imem_req  = ~rst & (state == S_FETCH) & ~hold;
  assign imem_addr = pc;

  // A returned word is taken only when it answers our own request and no redirect kills it.
  assign accept = (state == S_FETCH) & imem_req & imem_valid & ~redirect;

  // Next-state decode: redirect always lands in FLUSH, BOOT and FLUSH each last one cycle.
  always_comb begin
    state_nxt = state;
    if (redirect) begin
      state_nxt = S_FLUSH;
    end else begin
      case (state)
        S_BOOT:  state_nxt = S_FETCH;
        S_FETCH: state_nxt = S_FETCH;
        S_FLUSH: state_nxt = S_FETCH;
        default: state_nxt = S_BOOT;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_BOOT;
    end else begin
      state <= state_nxt;
    end
  end

  // PC: reload on redirect, advance on accept, otherwise hold (keeps imem_addr stable during waits).
  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RESET_PC;
    end else if (redirect) begin
      pc <= redirect_pc;
    end else if (accept) begin
      pc <= pc_plus4;
    end
  end

  // IF/ID valid: set on accept, cleared by redirect or by a bubble, held while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      if_valid <= 1'b0;
    end else if (redirect) begin
      if_valid <= 1'b0;
    end else if (accept) begin
      if_valid <= 1'b1;
    end else if (state != S_FETCH || !hold) begin
      if_valid <= 1'b0;
    end
  end

  // IF/ID payload and delivery counter only move when a word is accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      if_pc       <= 32'd0;
      if_instr    <= 32'd0;
      if_npc      <= 32'd0;
      fetch_count <= 32'd0;
    end else if (accept) begin
      if_pc       <= pc;
      if_instr    <= imem_rdata;
      if_npc      <= pc_plus4;
      fetch_count <= fetch_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_if_pc_ctrl.sv
// Bench for if_pc_ctrl: directed stimulus, behavioural memory with programmable latency,
// expected deliveries queued by the stimulus and popped by an independent monitor.
module tb_if_pc_ctrl;

  localparam logic [31:0] K = 32'hA5A5A5A5;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_valid;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic [31:0] if_npc;
  logic [31:0] fetch_count;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] npc;
    logic [31:0] cnt;
    logic [31:0] wt;
  } exp_t;

  exp_t sb[$];

  int n_checks = 0;
  int n_fail   = 0;

  // memory model state
  logic        mem_en;
  logic        force_valid;
  int          lat;
  int          wait_cnt;
  int          last_wait;
  logic [31:0] prev_cnt;

  if_pc_ctrl #(.RESET_PC(32'h00000000)) dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_valid  (imem_valid),
    .imem_rdata  (imem_rdata),
    .if_valid    (if_valid),
    .if_pc       (if_pc),
    .if_instr    (if_instr),
    .if_npc      (if_npc),
    .fetch_count (fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory answers a request on its lat-th consecutive request cycle.
  assign imem_valid = mem_en & ((imem_req & ((wait_cnt + 1) >= lat)) | force_valid);
  assign imem_rdata = imem_addr ^ K;

  always @(posedge clk) begin
    if (rst || !(imem_req && !imem_valid)) wait_cnt <= 0;
    else wait_cnt <= wait_cnt + 1;
    if (imem_req && imem_valid) last_wait <= wait_cnt + 1;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic push(input logic [31:0] pc, input logic [31:0] cnt, input logic [31:0] wt);
    exp_t e;
    e.pc  = pc;
    e.npc = pc + 32'd4;
    e.cnt = cnt;
    e.wt  = wt;
    sb.push_back(e);
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Monitor: every new delivery (valid with a changed counter) is checked against the queue head.
  initial prev_cnt = 32'd0;
  always @(negedge clk) begin
    if (!rst && if_valid && fetch_count !== prev_cnt) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_delivery: if_pc %h count %h with empty queue", if_pc, fetch_count);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("dlv_pc",    if_pc,       e.pc);
        chk("dlv_instr", if_instr,    e.pc ^ K);
        chk("dlv_npc",   if_npc,      e.npc);
        chk("dlv_count", fetch_count, e.cnt);
        chk("dlv_wait",  last_wait,   e.wt);
      end
    end
    prev_cnt = fetch_count;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'd0;
    mem_en = 1'b1; force_valid = 1'b0; lat = 1;
    step(); step();

    // reset state
    chk1("rst_req",   imem_req, 1'b0);
    chk1("rst_valid", if_valid, 1'b0);
    chk("rst_if_pc",  if_pc, 32'd0);
    chk("rst_instr",  if_instr, 32'd0);
    chk("rst_npc",    if_npc, 32'd0);
    chk("rst_count",  fetch_count, 32'd0);
    chk("rst_addr",   imem_addr, 32'd0);

    // back-to-back fetch with single-cycle memory, then a 2-cycle stall on if_pc=8
    push(32'd0, 32'd1, 32'd1);
    push(32'd4, 32'd2, 32'd1);
    push(32'd8, 32'd3, 32'd1);
    push(32'd12, 32'd4, 32'd1);
    rst = 1'b0;
    #1 chk1("boot_req", imem_req, 1'b0);
    step();
    chk1("fetch_req", imem_req, 1'b1);
    chk("fetch_addr", imem_addr, 32'd0);
    step(); step(); step();
    chk("pre_stall_pc", if_pc, 32'd8);
    stall = 1'b1;
    #1 chk1("stall_req", imem_req, 1'b0);
    step();
    chk("stall_pc",    if_pc, 32'd8);
    chk("stall_instr", if_instr, 32'd8 ^ K);
    chk("stall_count", fetch_count, 32'd3);
    chk1("stall_valid", if_valid, 1'b1);
    step();
    stall = 1'b0;
    #1 chk1("resume_req", imem_req, 1'b1);
    chk("resume_addr", imem_addr, 32'd12);
    step();
    chk("count_after4", fetch_count, 32'd4);

    // three-cycle memory latency
    lat = 3;
    push(32'd16, 32'd5, 32'd3);
    push(32'd20, 32'd6, 32'd3);
    push(32'd24, 32'd7, 32'd3);
    step();
    chk1("lat_bubble", if_valid, 1'b0);
    chk("lat_addr_hold", imem_addr, 32'd16);
    for (int i = 0; i < 20; i++) begin
      if (fetch_count == 32'd7) break;
      step();
    end
    chk("lat_count", fetch_count, 32'd7);

    // redirect with simultaneous stall and imem_valid
    stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h00000100; force_valid = 1'b1;
    #1 chk1("redir_stall_req", imem_req, 1'b0);
    step();
    stall = 1'b0; redirect = 1'b0; force_valid = 1'b0; lat = 1;
    chk1("redir_valid", if_valid, 1'b0);
    chk1("flush_req",   imem_req, 1'b0);
    chk("redir_addr",   imem_addr, 32'h00000100);
    chk("redir_count",  fetch_count, 32'd7);
    push(32'h00000100, 32'd8, 32'd1);
    step();
    chk1("post_flush_req", imem_req, 1'b1);
    chk("post_flush_addr", imem_addr, 32'h00000100);
    step();

    // redirect, then redirect again inside FLUSH to the top of the address space
    redirect = 1'b1; redirect_pc = 32'h00000300;
    step();
    chk1("flush2_req", imem_req, 1'b0);
    chk("flush2_addr", imem_addr, 32'h00000300);
    chk1("flush2_valid", if_valid, 1'b0);
    redirect_pc = 32'hFFFFFFFC;
    step();
    redirect = 1'b0;
    chk1("flush_reload_req", imem_req, 1'b0);
    chk("flush_reload_addr", imem_addr, 32'hFFFFFFFC);
    push(32'hFFFFFFFC, 32'd9, 32'd1);
    push(32'h00000000, 32'd10, 32'd1);
    step();
    chk1("wrap_req", imem_req, 1'b1);
    chk("wrap_addr", imem_addr, 32'hFFFFFFFC);
    step();
    chk("wrap_npc", if_npc, 32'h00000000);
    chk("wrap_next_addr", imem_addr, 32'h00000000);
    step();
    chk("wrap_count", fetch_count, 32'd10);

    // reset in the middle of a pending 3-cycle fetch
    lat = 3;
    step();
    chk1("pend_req", imem_req, 1'b1);
    chk("pend_addr", imem_addr, 32'd4);
    chk1("pend_valid", if_valid, 1'b0);
    rst = 1'b1;
    step();
    chk1("mid_rst_valid", if_valid, 1'b0);
    chk("mid_rst_count",  fetch_count, 32'd0);
    chk("mid_rst_if_pc",  if_pc, 32'd0);
    chk1("mid_rst_req",   imem_req, 1'b0);
    rst = 1'b0; lat = 1;
    push(32'd0, 32'd1, 32'd1);
    #1 chk1("reboot_req", imem_req, 1'b0);
    step();
    chk1("reboot_fetch_req", imem_req, 1'b1);
    chk("reboot_addr", imem_addr, 32'd0);
    step();
    mem_en = 1'b0;
    step(); step();
    chk("final_count", fetch_count, 32'd1);
    chk("queue_empty", sb.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/if_pc_ctrl.md
IF_PC_CTRL -- requirements
Module: if_pc_ctrl

Interface
REQ-001 Parameter RESET_PC, default 32'h00000000, is the first fetch address after reset.
REQ-002 clk  input  1  Rising-edge clock; the only clock in the block.
REQ-003 rst  input  1  Reset, synchronous and active-high.
REQ-004 stall  input  1  Hazard-unit hold: the IF/ID outputs shall be held.
REQ-005 redirect  input  1  Branch or jump taken; takes priority over stall.
REQ-006 redirect_pc  input  32  Target address, valid while redirect=1.
REQ-007 imem_req  output  1  Fetch request to instruction memory.
REQ-008 imem_addr  output  32  Fetch address; equals the PC register.
REQ-009 imem_valid  input  1  Memory returns data this cycle; meaningful only while imem_req=1.
REQ-010 imem_rdata  input  32  Instruction word, qualified by imem_valid.
REQ-011 if_valid  output  1  IF/ID outputs hold a live instruction.
REQ-012 if_pc  output  32  Address of the delivered instruction.
REQ-013 if_instr  output  32  Delivered instruction word.
REQ-014 if_npc  output  32  if_pc+4, used as the link and branch base.
REQ-015 fetch_count  output  32  Count of instructions delivered since reset.

Function
REQ-016 The block shall be an FSM with three states: BOOT, FETCH and FLUSH.
REQ-017 BOOT: imem_req=0 for exactly one cycle, then the FSM shall go to FETCH.
REQ-018 FETCH: imem_req = ~(stall & if_valid).
REQ-019 imem_addr shall stay stable while imem_req=1 and imem_valid=0, so memory latency may be any number of cycles.
REQ-020 Accept condition: FETCH & imem_valid & imem_req & ~redirect.
  - Registered next cycle: if_instr<=imem_rdata, if_pc<=pc, if_npc<=pc+4, if_valid<=1.
  - Also registered: pc<=pc+4, fetch_count+=1.
REQ-021 In FETCH with no accept, no redirect and stall=0, if_valid shall go to 0 on the next cycle (bubble).
REQ-022 With stall=1 and if_valid=1 and no redirect, all if_* outputs, pc and fetch_count shall hold.
REQ-023 On redirect=1 in any non-reset state:
  - pc<=redirect_pc and if_valid<=0 next cycle.
  - imem_valid in that cycle shall be ignored.
  - The FSM shall go to FLUSH.
REQ-024 FLUSH: imem_req=0 for one cycle, then FETCH. A redirect during FLUSH shall reload pc and stay in FLUSH one more cycle.
REQ-025 All address arithmetic shall be modulo 2^32: pc 32'hFFFFFFFC +4 wraps to 32'h00000000 without error.
REQ-026 fetch_count shall wrap from 32'hFFFFFFFF to 0.
REQ-027 redirect_pc shall be used unmodified; alignment is the requester's responsibility.
REQ-028 The if_* outputs, imem_addr and fetch_count shall come directly from registers; imem_req is decoded from state, stall and if_valid.

Reset
REQ-029 While rst=1 at a clock edge, the block shall set:
  - state=BOOT, pc=RESET_PC, if_valid=0;
  - if_pc=0, if_instr=0, if_npc=0, fetch_count=0.
REQ-030 During reset imem_req shall be 0. rst shall override redirect, stall and any in-flight fetch, including mid-FLUSH and mid-wait.

Verification
REQ-031 Reset release, imem_valid=1 every FETCH cycle, rdata=addr^32'hA5A5A5A5 -> BOOT 1 cycle; if_pc sequence 0,4,8,12 on consecutive cycles; fetch_count=4 after the fourth.
REQ-032 Memory latency 3 cycles (imem_valid on the 3rd request cycle) -> imem_addr held 3 cycles; if_valid=0 between deliveries; if_pc increments by 4 per delivery.
REQ-033 stall=1 for 2 cycles with if_pc=8 valid -> imem_req=0; if_pc=8, if_instr and fetch_count unchanged; delivery resumes at pc 12 after stall drops.
REQ-034 redirect=1 with redirect_pc=32'h00000100 and stall=1 and imem_valid=1 in the same cycle -> if_valid=0, FLUSH 1 cycle, next request address 32'h100, fetch_count not incremented.
REQ-035 Redirect to 32'hFFFFFFFC -> delivered if_pc FFFFFFFC with if_npc 00000000, next fetch address 00000000.
REQ-036 rst=1 asserted during a pending 3-cycle fetch -> next cycle if_valid=0, fetch_count=0; the first post-reset request is to RESET_PC after one BOOT cycle.
